ring_position_monitor: RTL and testbench
========================================

# ring_position_monitor

Downstream consumer of the one-hot ring counter output. Each cycle it samples the ring value, encodes the hot bit to a binary index, and checks that the ring moves exactly one position per step in the expected direction. It also counts full revolutions and records one-hot and sequence faults in sticky flags plus a saturating error counter. Firmware and the top-level output mux read these registered results for status and self-test.

## Interface
Parameters:
- WIDTH, 8: ring width in bits; power of two, ≥2; IDX_W = log2(WIDTH)
- REV_W, 8: revolution counter width
- ERR_W, 4: error counter width
Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset; dominates every other input
- ring  in  WIDTH  ring counter state; one hot bit expected
- step  in  1  ring advanced on this cycle; sampled together with ring
- dir  in  1  0: expected next = idx+1 mod WIDTH; 1: expected next = idx−1 mod WIDTH
- clr_err  in  1  clear sticky flags and err_count
- idx  out  IDX_W  binary position of the hot bit
- idx_valid  out  1  high while in TRACK
- rev_tick  out  1  one-cycle pulse on each completed revolution
- rev_count  out  REV_W  revolutions, wraps modulo 2^REV_W
- err_onehot  out  1  sticky: ring had zero hot bits or more than one
- err_seq  out  1  sticky: ring moved to an unexpected position
- err_count  out  ERR_W  total fault events; saturates at all-ones

## Operation
- onehot_ok is true when popcount(ring) == 1; new_idx is the encoded position of that bit.
- FSM has 2 states, SYNC and TRACK. Reset state is SYNC.
- SYNC:
  - If onehot_ok: load idx = new_idx and go to TRACK. No sequence check and no rev_tick.
  - Otherwise: stay in SYNC with no error. An all-zero or multi-hot ring during startup is not a fault.
- TRACK, checked in this priority order:
  1. !onehot_ok: set err_onehot, increment err_count, go to SYNC. idx holds its last value. step is ignored.
  2. step=1 and new_idx == expected: update idx. If the move wraps (WIDTH−1→0 with dir=0, or 0→WIDTH−1 with dir=1), pulse rev_tick and increment rev_count.
  3. step=1 and new_idx != expected: set err_seq, increment err_count, load idx = new_idx (resync), stay in TRACK. No rev_tick.
  4. step=0 and new_idx != idx: treat as an unexpected move. Same actions as rule 3.
  5. step=0 and new_idx == idx: hold.
- A cycle counts as at most one fault event. err_count increments by at most 1 per cycle and saturates at 2^ERR_W−1.
- clr_err=1 clears err_onehot, err_seq and err_count. If a fault is detected in the same cycle, the fault wins: its flag is set and err_count = 1. Error flags of the other kind are cleared.
- clr_err has no effect on the FSM, idx or rev_count.
- dir is sampled on every step, so a direction change takes effect on the next check.

## Timing
- All outputs are registered. Inputs sampled at rising edge N appear on the outputs immediately after edge N (1-cycle latency).
- Reset value of every output is 0: idx, idx_valid, rev_tick, rev_count, err_onehot, err_seq, err_count. FSM resets to SYNC.
- rst asserted mid-operation: all outputs are 0 after that edge, regardless of step, clr_err or ring. Tracking restarts from SYNC on the first cycle after rst deasserts.
- idx_valid rises one edge after the first valid one-hot sample and falls on the edge that registers the one-hot fault.
- rev_tick is high for exactly one cycle per wrap. Back-to-back wraps (WIDTH=2) produce a tick on consecutive cycles.
- step is level-sampled per cycle; holding step high for k cycles means k advances are expected.

## Test plan
- Reset/sync: hold rst 3 cycles with ring=8'h01, then release. All outputs are 0 during reset. One edge after release: idx=0, idx_valid=1, err_count=0.
- Forward revolution: starting from ring=01, dir=0, apply 8 steps through 02,04,…,80,01. idx follows 1..7,0. rev_tick pulses once on the 80→01 edge, rev_count=1, no errors.
- Reverse with direction change: from idx=0 with dir=1, step to 80 → rev_tick, rev_count increments. Then set dir=0 and step 80→01 → another rev_tick, no errors.
- Sequence fault: from idx=2 (ring 04), step with ring=10. Result: err_seq=1, err_count=1, idx=4, idx_valid stays 1. Next, ring changes 10→20 with step=0 → err_count=2.
- One-hot fault and clear: in TRACK, drive ring=8'h03 with step=1. Result: err_onehot=1, err_count+1, idx_valid=0, state SYNC. Then ring=8'h00 gives no further count. Then ring=8'h08 resyncs to idx=3. Assert clr_err together with ring=8'h00 → err_onehot=1, err_count=1 (fault wins).
- Saturation: ERR_W=4, force 20 sequence faults → err_count stays at 15.

Source files
------------

// File: rtl/ring_position_monitor.sv
// Tracks a one-hot ring counter: encodes the hot bit, checks single-step motion
// in the commanded direction, counts revolutions and records faults.
//
// state | meaning
// SYNC  | waiting for a clean one-hot sample to lock onto
// TRACK | locked; every sample is checked against the expected position
module ring_position_monitor #(
  parameter int WIDTH = 8,
  parameter int REV_W = 8,
  parameter int ERR_W = 4,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] ring,
  input  logic             step,
  input  logic             dir,
  input  logic             clr_err,
  output logic [IDX_W-1:0] idx,
  output logic             idx_valid,
  output logic             rev_tick,
  output logic [REV_W-1:0] rev_count,
  output logic             err_onehot,
  output logic             err_seq,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic {SYNC = 1'b0, TRACK = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             rev_tick_q, rev_tick_d;
  logic [REV_W-1:0] rev_count_q, rev_count_d;
  logic             err_onehot_q, err_onehot_d;
  logic             err_seq_q, err_seq_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;

  logic             onehot_ok;
  logic [IDX_W-1:0] new_idx;
  logic [IDX_W-1:0] expected;
  logic             wraps;
  logic             fault_oh, fault_seq;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign onehot_ok = (ring != '0) && ((ring & (ring - WIDTH'(1))) == '0);

  always_comb begin
    new_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (ring[i]) new_idx = IDX_W'(i);
    end
  end

  // WIDTH is a power of two, so modulo arithmetic is plain IDX_W-bit wrap.
  assign expected = dir ? (idx_q - IDX_W'(1)) : (idx_q + IDX_W'(1));
  assign wraps    = dir ? (idx_q == '0) : (idx_q == IDX_W'(WIDTH - 1));

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rev_tick_d  = 1'b0;
    rev_count_d = rev_count_q;
    fault_oh    = 1'b0;
    fault_seq   = 1'b0;
    case (state_q)
      SYNC: begin
        if (onehot_ok) begin
          state_d = TRACK;
          idx_d   = new_idx;
        end
      end
      TRACK: begin
        if (!onehot_ok) begin
          fault_oh = 1'b1;
          state_d  = SYNC;
        end else if (step) begin
          idx_d = new_idx;
          if (new_idx == expected) begin
            if (wraps) begin
              rev_tick_d  = 1'b1;
              rev_count_d = rev_count_q + REV_W'(1);
            end
          end else begin
            fault_seq = 1'b1;
          end
        end else if (new_idx != idx_q) begin
          fault_seq = 1'b1;
          idx_d     = new_idx;
        end
      end
      default: state_d = SYNC;
    endcase
  end

  // A fault in the same cycle as a clear survives the clear as a fresh count of one.
  always_comb begin
    err_onehot_d = err_onehot_q;
    err_seq_d    = err_seq_q;
    err_count_d  = err_count_q;
    if (clr_err) begin
      err_onehot_d = fault_oh;
      err_seq_d    = fault_seq;
      err_count_d  = (fault_oh || fault_seq) ? ERR_W'(1) : '0;
    end else begin
      err_onehot_d = err_onehot_q | fault_oh;
      err_seq_d    = err_seq_q | fault_seq;
      if ((fault_oh || fault_seq) && !(&err_count_q)) begin
        err_count_d = err_count_q + ERR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SYNC;
      idx_q        <= '0;
      rev_tick_q   <= 1'b0;
      rev_count_q  <= '0;
      err_onehot_q <= 1'b0;
      err_seq_q    <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      rev_tick_q   <= rev_tick_d;
      rev_count_q  <= rev_count_d;
      err_onehot_q <= err_onehot_d;
      err_seq_q    <= err_seq_d;
      err_count_q  <= err_count_d;
    end
  end

  assign idx        = idx_q;
  assign idx_valid  = (state_q == TRACK);
  assign rev_tick   = rev_tick_q;
  assign rev_count  = rev_count_q;
  assign err_onehot = err_onehot_q;
  assign err_seq    = err_seq_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_ring_position_monitor.sv
// Directed scenarios plus randomized traffic for ring_position_monitor, checked
// against a position/popcount reference model.
module tb_ring_position_monitor;
  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] ring = 8'h00;
  logic       step = 1'b0;
  logic       dir = 1'b0;
  logic       clr_err = 1'b0;
  logic [2:0] idx;
  logic       idx_valid, rev_tick, err_onehot, err_seq;
  logic [7:0] rev_count;
  logic [3:0] err_count;

  int n_checks = 0;
  int n_fail = 0;

  // reference model state
  bit m_track;
  int m_idx, m_rev, m_ec;
  bit m_tick, m_eo, m_es;

  ring_position_monitor #(.WIDTH(8), .REV_W(8), .ERR_W(4)) dut (
    .clk(clk), .rst(rst), .ring(ring), .step(step), .dir(dir), .clr_err(clr_err),
    .idx(idx), .idx_valid(idx_valid), .rev_tick(rev_tick), .rev_count(rev_count),
    .err_onehot(err_onehot), .err_seq(err_seq), .err_count(err_count)
  );

  always #5 clk = ~clk;

  function automatic int pos_of(input logic [7:0] r);
    int p = 0;
    for (int i = 0; i < W; i++) if (r[i]) p = i;
    return p;
  endfunction

  task automatic model_update();
    int pc, pos, exp_pos;
    bit fo, fs;
    fo = 0; fs = 0; m_tick = 0;
    if (rst) begin
      m_track = 0; m_idx = 0; m_rev = 0; m_eo = 0; m_es = 0; m_ec = 0;
      return;
    end
    pc = $countones(ring);
    pos = pos_of(ring);
    if (!m_track) begin
      if (pc == 1) begin m_track = 1; m_idx = pos; end
    end else if (pc != 1) begin
      fo = 1; m_track = 0;
    end else if (step) begin
      exp_pos = dir ? (m_idx + W - 1) % W : (m_idx + 1) % W;
      if (pos == exp_pos) begin
        if (pos == 0 && !dir || pos == W - 1 && dir) begin
          m_tick = 1; m_rev = (m_rev + 1) % 256;
        end
      end else fs = 1;
      m_idx = pos;
    end else if (pos != m_idx) begin
      fs = 1; m_idx = pos;
    end
    if (clr_err) begin
      m_eo = fo; m_es = fs; m_ec = (fo || fs) ? 1 : 0;
    end else begin
      m_eo = m_eo | fo; m_es = m_es | fs;
      if ((fo || fs) && m_ec < 15) m_ec++;
    end
  endtask

  task automatic cyc(input logic r, input logic [7:0] rg, input logic st,
                     input logic d, input logic c);
    rst = r; ring = rg; step = st; dir = d; clr_err = c;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(1, 8'h01, 1, 0, 0);
      n_checks++;
      if ({idx, idx_valid, rev_tick, rev_count, err_onehot, err_seq, err_count} !== 19'd0) begin
        n_fail++;
        $display("FAIL reset_outputs cycle %0d got idx=%0d v=%0b t=%0b rc=%0d eo=%0b es=%0b ec=%0d need all 0",
                 i, idx, idx_valid, rev_tick, rev_count, err_onehot, err_seq, err_count);
      end
    end
    cyc(0, 8'h01, 0, 0, 0);
    n_checks++;
    if (idx !== 3'd0 || idx_valid !== 1'b1 || err_count !== 4'd0) begin
      n_fail++;
      $display("FAIL sync_after_reset got idx=%0d v=%0b ec=%0d need 0 1 0", idx, idx_valid, err_count);
    end
  endtask

  task automatic test_forward();
    logic [7:0] r;
    for (int i = 1; i <= 8; i++) begin
      r = 8'h01 << (i % 8);
      cyc(0, r, 1, 0, 0);
      n_checks++;
      if (idx !== 3'(i % 8) || rev_tick !== (i == 8)) begin
        n_fail++;
        $display("FAIL fwd_step %0d got idx=%0d tick=%0b need idx=%0d tick=%0b", i, idx, rev_tick, i % 8, i == 8);
      end
    end
    n_checks++;
    if (rev_count !== 8'd1 || err_count !== 4'd0 || err_seq !== 1'b0 || err_onehot !== 1'b0) begin
      n_fail++;
      $display("FAIL fwd_totals got rc=%0d ec=%0d es=%0b eo=%0b need 1 0 0 0", rev_count, err_count, err_seq, err_onehot);
    end
  endtask

  task automatic test_reverse_dirchange();
    cyc(0, 8'h80, 1, 1, 0);
    n_checks++;
    if (idx !== 3'd7 || rev_tick !== 1'b1 || rev_count !== 8'd2) begin
      n_fail++;
      $display("FAIL rev_wrap got idx=%0d tick=%0b rc=%0d need 7 1 2", idx, rev_tick, rev_count);
    end
    cyc(0, 8'h01, 1, 0, 0);
    n_checks++;
    if (idx !== 3'd0 || rev_tick !== 1'b1 || rev_count !== 8'd3 || err_count !== 4'd0) begin
      n_fail++;
      $display("FAIL dirchange_wrap got idx=%0d tick=%0b rc=%0d ec=%0d need 0 1 3 0", idx, rev_tick, rev_count, err_count);
    end
    cyc(0, 8'h01, 0, 0, 0);
    n_checks++;
    if (rev_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL tick_one_cycle got %0b need 0", rev_tick);
    end
  endtask

  task automatic test_seq_fault();
    cyc(0, 8'h02, 1, 0, 0);
    cyc(0, 8'h04, 1, 0, 0);
    cyc(0, 8'h10, 1, 0, 0);
    n_checks++;
    if (err_seq !== 1'b1 || err_count !== 4'd1 || idx !== 3'd4 || idx_valid !== 1'b1 || rev_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL seq_fault got es=%0b ec=%0d idx=%0d v=%0b t=%0b need 1 1 4 1 0",
               err_seq, err_count, idx, idx_valid, rev_tick);
    end
    cyc(0, 8'h20, 0, 0, 0);
    n_checks++;
    if (err_count !== 4'd2 || idx !== 3'd5) begin
      n_fail++;
      $display("FAIL move_no_step got ec=%0d idx=%0d need 2 5", err_count, idx);
    end
  endtask

  task automatic test_onehot_clear();
    cyc(0, 8'h03, 1, 0, 0);
    n_checks++;
    if (err_onehot !== 1'b1 || err_count !== 4'd3 || idx_valid !== 1'b0 || idx !== 3'd5) begin
      n_fail++;
      $display("FAIL onehot_fault got eo=%0b ec=%0d v=%0b idx=%0d need 1 3 0 5", err_onehot, err_count, idx_valid, idx);
    end
    cyc(0, 8'h00, 0, 0, 0);
    n_checks++;
    if (err_count !== 4'd3 || idx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL sync_zero_no_fault got ec=%0d v=%0b need 3 0", err_count, idx_valid);
    end
    cyc(0, 8'h08, 0, 0, 0);
    n_checks++;
    if (idx !== 3'd3 || idx_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL resync got idx=%0d v=%0b need 3 1", idx, idx_valid);
    end
    cyc(0, 8'h00, 0, 0, 1);
    n_checks++;
    if (err_onehot !== 1'b1 || err_seq !== 1'b0 || err_count !== 4'd1 || rev_count !== 8'd3) begin
      n_fail++;
      $display("FAIL clr_fault_wins got eo=%0b es=%0b ec=%0d rc=%0d need 1 0 1 3", err_onehot, err_seq, err_count, rev_count);
    end
  endtask

  task automatic test_saturation();
    cyc(0, 8'h01, 0, 0, 0);
    cyc(0, 8'h01, 0, 0, 1);
    n_checks++;
    if (err_count !== 4'd0 || err_onehot !== 1'b0 || err_seq !== 1'b0 || idx_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_plain got ec=%0d eo=%0b es=%0b v=%0b need 0 0 0 1", err_count, err_onehot, err_seq, idx_valid);
    end
    for (int i = 0; i < 20; i++) begin
      cyc(0, (i % 2 == 0) ? 8'h10 : 8'h01, 0, 0, 0);
      n_checks++;
      if (err_count !== 4'((i + 1 > 15) ? 15 : i + 1)) begin
        n_fail++;
        $display("FAIL saturate fault %0d got ec=%0d need %0d", i + 1, err_count, (i + 1 > 15) ? 15 : i + 1);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] r;
    logic st, d, c, rs;
    int kind;
    cyc(1, 8'h00, 0, 0, 0);
    for (int n = 0; n < 600; n++) begin
      kind = $urandom_range(0, 19);
      d = 1'($urandom_range(0, 1));
      st = 1'b0;
      if (kind < 12) begin
        st = 1'b1;
        r = 8'h01 << (d ? (m_idx + W - 1) % W : (m_idx + 1) % W);
      end else if (kind < 15) r = 8'h01 << m_idx;
      else if (kind < 17) begin
        r = 8'h01 << $urandom_range(0, 7);
        st = 1'($urandom_range(0, 1));
      end else if (kind == 17) r = 8'h00;
      else r = 8'($urandom_range(0, 255)) | 8'h81;
      c = ($urandom_range(0, 29) == 0);
      rs = ($urandom_range(0, 99) == 0);
      cyc(rs, r, st, d, c);
      n_checks++;
      if (idx !== 3'(m_idx) || idx_valid !== m_track || rev_tick !== m_tick || rev_count !== 8'(m_rev) ||
          err_onehot !== m_eo || err_seq !== m_es || err_count !== 4'(m_ec)) begin
        n_fail++;
        $display("FAIL random cyc %0d got idx=%0d v=%0b t=%0b rc=%0d eo=%0b es=%0b ec=%0d need %0d %0b %0b %0d %0b %0b %0d",
                 n, idx, idx_valid, rev_tick, rev_count, err_onehot, err_seq, err_count,
                 m_idx, m_track, m_tick, m_rev, m_eo, m_es, m_ec);
      end
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reverse_dirchange();
    test_seq_fault();
    test_onehot_clear();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
